// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU op
// encodings and the bit positions of the fields packed into ctrl_ex.
package ex_stage_pkg;

   localparam int XLEN       = 32;
   localparam int CTRL_W     = 9;

   // ctrl_ex field layout
   localparam int MEMWB_HI   = 8;
   localparam int MEMWB_LO   = 4;
   localparam int MEMWB_W    = MEMWB_HI - MEMWB_LO + 1;
   localparam int ALUOP_HI   = 3;
   localparam int ALUOP_LO   = 1;
   localparam int ALUOP_W    = ALUOP_HI - ALUOP_LO + 1;
   localparam int ALUSRC_BIT = 0;

   // ALU operations; 3'b110 and 3'b111 are reserved and produce zero
   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLL = 3'b100,
      ALU_SLT = 3'b101
   } alu_op_e;

   // Extract the ALU op field from a packed EX control word
   function automatic logic [ALUOP_W-1:0] ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
      return ctrl[ALUOP_HI:ALUOP_LO];
   endfunction

   // Extract the MEM/WB pass-through slice from a packed EX control word
   function automatic logic [MEMWB_W-1:0] ctrl_memwb(input logic [CTRL_W-1:0] ctrl);
      return ctrl[MEMWB_HI:MEMWB_LO];
   endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 32-bit ALU: ADD, SUB, AND, OR, SLL, signed SLT.
// Reserved op codes return zero.
module alu
   import ex_stage_pkg::*;
(
   input  logic [XLEN-1:0]    a,
   input  logic [XLEN-1:0]    b,
   input  logic [ALUOP_W-1:0] op,
   output logic [XLEN-1:0]    result
);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic [XLEN-1:0] and_bits;
   logic [XLEN-1:0] or_bits;
   logic [XLEN-1:0] shl;
   logic            lt_signed;

   // Adder and subtractor; both wrap modulo 2^32
   assign sum  = a + b;
   assign diff = a - b;

   // Bitwise logic, one slice per bit
   genvar gi;
   generate
      for (gi = 0; gi < XLEN; gi++) begin : g_bitwise
         assign and_bits[gi] = a[gi] & b[gi];
         assign or_bits[gi]  = a[gi] | b[gi];
      end
   endgenerate

   // Only the low five bits of b form the shift amount
   assign shl = a << b[4:0];

   // Signed less-than reusing the subtractor: with differing signs the
   // negative operand is smaller; with equal signs a - b cannot overflow,
   // so its sign bit is the answer
   assign lt_signed = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

   // Result select by op code
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = sum;
         ALU_SUB: result = diff;
         ALU_AND: result = and_bits;
         ALU_OR:  result = or_bits;
         ALU_SLL: result = shl;
         ALU_SLT: result = {{(XLEN-1){1'b0}}, lt_signed};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand B select, ALU, and the EX/MEM pipeline register.
// Every output comes straight from a flop; reset clears them at once.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [CTRL_W-1:0]  ctrl_ex,
   input  logic [XLEN-1:0]    rd_ex,
   input  logic [XLEN-1:0]    pc4_ex,
   input  logic [XLEN-1:0]    r_data1,
   input  logic [XLEN-1:0]    r_data2,
   input  logic [XLEN-1:0]    extended,
   output logic [MEMWB_W-1:0] ctrl_mem,
   output logic [XLEN-1:0]    rd_mem,
   output logic [XLEN-1:0]    pc4_mem,
   output logic [XLEN-1:0]    alu_result,
   output logic [XLEN-1:0]    write_data1
);

   logic [XLEN-1:0]    operand_b;
   logic [XLEN-1:0]    alu_out;

   logic [MEMWB_W-1:0] ctrl_mem_reg;
   logic [XLEN-1:0]    rd_mem_reg;
   logic [XLEN-1:0]    pc4_mem_reg;
   logic [XLEN-1:0]    alu_result_reg;
   logic [XLEN-1:0]    write_data1_reg;

   // Operand B: immediate when ALUSrc is set, otherwise rs2
   assign operand_b = ctrl_ex[ALUSRC_BIT] ? extended : r_data2;

   alu u_alu (
      .a      (r_data1),
      .b      (operand_b),
      .op     (ctrl_alu_op(ctrl_ex)),
      .result (alu_out)
   );

   // EX/MEM register: loads every cycle, cleared asynchronously by reset.
   // Store data is always rs2, independent of the operand B select.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_mem_reg    <= '0;
         rd_mem_reg      <= '0;
         pc4_mem_reg     <= '0;
         alu_result_reg  <= '0;
         write_data1_reg <= '0;
      end else begin
         ctrl_mem_reg    <= ctrl_memwb(ctrl_ex);
         rd_mem_reg      <= rd_ex;
         pc4_mem_reg     <= pc4_ex;
         alu_result_reg  <= alu_out;
         write_data1_reg <= r_data2;
      end
   end

   assign ctrl_mem    = ctrl_mem_reg;
   assign rd_mem      = rd_mem_reg;
   assign pc4_mem     = pc4_mem_reg;
   assign alu_result  = alu_result_reg;
   assign write_data1 = write_data1_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: expected EX/MEM contents are queued when
// a transaction is driven and compared one cycle later.
module tb_ex_stage;

   logic        clk;
   logic        reset;
   logic [8:0]  ctrl_ex;
   logic [31:0] rd_ex;
   logic [31:0] pc4_ex;
   logic [31:0] r_data1;
   logic [31:0] r_data2;
   logic [31:0] extended;
   logic [4:0]  ctrl_mem;
   logic [31:0] rd_mem;
   logic [31:0] pc4_mem;
   logic [31:0] alu_result;
   logic [31:0] write_data1;

   typedef struct {
      string       tag;
      logic [4:0]  ctrl;
      logic [31:0] rd;
      logic [31:0] pc4;
      logic [31:0] alu;
      logic [31:0] wd;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_mis;

   ex_stage dut (
      .clk         (clk),
      .reset       (reset),
      .ctrl_ex     (ctrl_ex),
      .rd_ex       (rd_ex),
      .pc4_ex      (pc4_ex),
      .r_data1     (r_data1),
      .r_data2     (r_data2),
      .extended    (extended),
      .ctrl_mem    (ctrl_mem),
      .rd_mem      (rd_mem),
      .pc4_mem     (pc4_mem),
      .alu_result  (alu_result),
      .write_data1 (write_data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference ALU written from the operation table
   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a << b[4:0];
         3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, ".ctrl_mem"}, {27'd0, ctrl_mem}, 32'd0);
      check({tag, ".rd_mem"}, rd_mem, 32'd0);
      check({tag, ".pc4_mem"}, pc4_mem, 32'd0);
      check({tag, ".alu_result"}, alu_result, 32'd0);
      check({tag, ".write_data1"}, write_data1, 32'd0);
   endtask

   // Drive one transaction on the falling edge, queue its expectation,
   // then compare after the capturing rising edge
   task automatic xact(input string tag, input logic [4:0] mw, input logic [2:0] op,
                       input logic src, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] ext, input logic [31:0] exp_alu,
                       input logic [31:0] rd_v, input logic [31:0] pc4_v);
      exp_t e;
      exp_t o;
      @(negedge clk);
      ctrl_ex  = {mw, op, src};
      rd_ex    = rd_v;
      pc4_ex   = pc4_v;
      r_data1  = a;
      r_data2  = r2;
      extended = ext;
      e.tag  = tag;
      e.ctrl = mw;
      e.rd   = rd_v;
      e.pc4  = pc4_v;
      e.alu  = exp_alu;
      e.wd   = r2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         o = sb.pop_front();
         check({o.tag, ".ctrl_mem"}, {27'd0, ctrl_mem}, {27'd0, o.ctrl});
         check({o.tag, ".rd_mem"}, rd_mem, o.rd);
         check({o.tag, ".pc4_mem"}, pc4_mem, o.pc4);
         check({o.tag, ".alu_result"}, alu_result, o.alu);
         check({o.tag, ".write_data1"}, write_data1, o.wd);
         $display("xact %-10s ctrl=%b rd=%h pc4=%h alu=%h wd=%h", o.tag,
                  ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1);
      end
   endtask

   // Shorthand with random pass-through fields
   task automatic op_x(input string tag, input logic [2:0] op, input logic src,
                       input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] ext, input logic [31:0] exp_alu);
      xact(tag, 5'($urandom), op, src, a, r2, ext, exp_alu, $urandom, $urandom);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      n_cmp    = 0;
      n_mis    = 0;
      reset    = 1'b1;
      ctrl_ex  = 9'h1FF;
      rd_ex    = 32'h12345678;
      pc4_ex   = 32'h9ABCDEF0;
      r_data1  = 32'h0000_0005;
      r_data2  = 32'h0000_0007;
      extended = 32'h0000_0009;

      // Held in reset across edges with busy inputs: everything stays zero
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");

      // Release; the very next rising edge captures the pass-through pattern
      reset = 1'b0;
      xact("passthru", 5'b11111, 3'b000, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

      // ADD / SUB, including wrap-around
      op_x("add_reg",  3'd0, 1'b0, 32'd1073741823, 32'd1, 32'd999, 32'd1073741824);
      op_x("add_imm",  3'd0, 1'b1, -32'sd70, 32'hDEADBEEF, 32'd5, -32'sd65);
      op_x("sub_imm",  3'd1, 1'b1, 32'd81, 32'h0BADF00D, 32'd970, -32'sd889);
      op_x("add_wrap", 3'd0, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h80000000);
      op_x("sub_wrap", 3'd1, 1'b0, 32'h0, 32'd1, 32'd0, 32'hFFFFFFFF);

      // AND / OR with register and immediate operands
      op_x("and_reg", 3'd2, 1'b0, 32'hCCCCCCCC, 32'hAAAAAAAA, 32'h0, 32'h88888888);
      op_x("or_reg",  3'd3, 1'b0, 32'hCCCCCCCC, 32'hAAAAAAAA, 32'h0, 32'hEEEEEEEE);
      op_x("and_imm", 3'd2, 1'b1, 32'h33333333, 32'hFFFFFFFF, 32'h55555555, 32'h11111111);
      op_x("or_imm",  3'd3, 1'b1, 32'h33333333, 32'h0, 32'h55555555, 32'h77777777);

      // SLL, with the upper shift-amount bits ignored
      op_x("sll_reg", 3'd4, 1'b0, 32'hAAAAAAAA, 32'd1, 32'd7, 32'h55555554);
      op_x("sll_imm", 3'd4, 1'b1, 32'h55555555, 32'd9, 32'd2, 32'h55555554);
      op_x("sll_b21", 3'd4, 1'b0, 32'h00000003, 32'h21, 32'd0, 32'h00000006);

      // Signed SLT
      op_x("slt_r1", 3'd5, 1'b0, 32'd10, 32'd80, 32'd0, 32'd1);
      op_x("slt_r2", 3'd5, 1'b0, -32'sd10, -32'sd10, 32'd0, 32'd0);
      op_x("slt_r3", 3'd5, 1'b0, 32'd10, -32'sd105, 32'd0, 32'd0);
      op_x("slt_i1", 3'd5, 1'b1, -32'sd87, 32'd0, 32'd105, 32'd1);
      op_x("slt_i2", 3'd5, 1'b1, 32'd87, 32'd5, 32'd87, 32'd0);
      op_x("slt_i3", 3'd5, 1'b1, -32'sd87, 32'd5, -32'sd287, 32'd0);

      // Reserved op codes
      op_x("rsv_110", 3'd6, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'd0);
      op_x("rsv_111", 3'd7, 1'b1, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'd0);

      // Asynchronous reset between edges while outputs are nonzero
      op_x("pre_rst", 3'd0, 1'b0, 32'h100, 32'h23, 32'h0, 32'h123);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
      reset = 1'b0;

      // Randomised mix against the reference model
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  op;
         logic        src;
         logic [31:0] a, r2, ext;
         op  = 3'($urandom_range(0, 7));
         src = 1'($urandom);
         a   = $urandom;
         r2  = $urandom;
         ext = $urandom;
         op_x($sformatf("rand%0d", i), op, src, a, r2, ext,
              ref_alu(op, a, src ? ext : r2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
